// File: rtl/audio_mem_burst_writer_pkg.sv
// Shared defaults for the audio memory burst writer and its ring address generator.
// Mirrors the system-level burst, data-width and audio-buffer settings.
package audio_mem_burst_writer_pkg;

    localparam int MEM_WR_BL     = 16;
    localparam int DSIZE         = 36;
    localparam int AUD_AW        = 24;
    localparam int AUD_BUF_BASE  = 0;
    localparam int AUD_BUF_WORDS = 65536;
    localparam int AUD_STALL_MAX = 1024;

    // Counter width that stays at least one bit for degenerate sizes
    function automatic int cnt_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/audio_ring_addr_gen.sv
// Circular buffer pointer: advances by one burst and wraps back to the ring base.
// Shared by the audio write path and the audio readback path.
module audio_ring_addr_gen
    import audio_mem_burst_writer_pkg::*;
#(
    parameter int BASE_ADDR = AUD_BUF_BASE,
    parameter int BUF_WORDS = AUD_BUF_WORDS,
    parameter int BL        = MEM_WR_BL,
    parameter int AW        = AUD_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          advance,
    output logic [AW-1:0] ptr,
    output logic [15:0]   wrap_cnt
);

    // Ring end may equal 2^AW, so the compare carries one extra bit
    localparam longint END_L = longint'(BASE_ADDR) + longint'(BUF_WORDS);
    localparam logic [AW:0] END_ADDR = (AW+1)'(END_L);
    localparam logic [AW-1:0] BASE = AW'(BASE_ADDR);

    logic [AW:0] nxt;
    logic        wrap;

    assign nxt  = {1'b0, ptr} + (AW+1)'(BL);
    assign wrap = (nxt == END_ADDR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr      <= BASE;
            wrap_cnt <= '0;
        end else if (advance) begin
            ptr      <= wrap ? BASE : nxt[AW-1:0];
            wrap_cnt <= wrap_cnt + 16'(wrap);
        end
    end

endmodule

// File: rtl/audio_mem_burst_writer.sv
// Drains fixed-length PCM bursts from the audio FIFO into the external ring buffer.
// Issues one write command per burst, then streams BL beats straight from the FIFO head.
module audio_mem_burst_writer
    import audio_mem_burst_writer_pkg::*;
#(
    parameter int BL        = MEM_WR_BL,
    parameter int DW        = DSIZE,
    parameter int AW        = AUD_AW,
    parameter int BASE_ADDR = AUD_BUF_BASE,
    parameter int BUF_WORDS = AUD_BUF_WORDS,
    parameter int STALL_MAX = AUD_STALL_MAX
) (
    input  logic          rd_clk,
    input  logic          wr_rst,
    input  logic          enable,
    input  logic          burst_avail,
    output logic          burst_rd_en,
    input  logic [DW-1:0] burst_rd_data,
    output logic          mem_cmd_vld,
    input  logic          mem_cmd_rdy,
    output logic [AW-1:0] mem_cmd_addr,
    output logic          mem_wr_vld,
    input  logic          mem_wr_rdy,
    output logic [DW-1:0] mem_wr_data,
    output logic          mem_wr_last,
    output logic [AW-1:0] wr_ptr,
    output logic [15:0]   wrap_cnt,
    output logic          busy,
    output logic          err_stall
);

    localparam int BW = cnt_bits(BL);
    localparam int SW = cnt_bits(STALL_MAX + 1);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BL - 1);
    localparam logic [SW-1:0] STALL_TOP = SW'(STALL_MAX);
    localparam logic [SW-1:0] STALL_PRE = SW'(STALL_MAX - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2,
        POST = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [BW-1:0] beat;
    logic          post_cnt;
    logic [SW-1:0] stall_cnt;
    logic [AW-1:0] cmd_addr;
    logic          hs;
    logic          stall;
    logic          start;
    logic          advance;

    always_comb begin
        state_nxt   = state;
        mem_cmd_vld = 1'b0;
        mem_wr_vld  = 1'b0;
        mem_wr_last = 1'b0;
        start       = 1'b0;
        unique case (state)
            IDLE: begin
                if (enable && burst_avail) begin
                    start     = 1'b1;
                    state_nxt = CMD;
                end
            end
            CMD: begin
                mem_cmd_vld = 1'b1;
                if (mem_cmd_rdy)
                    state_nxt = DATA;
            end
            DATA: begin
                mem_wr_vld  = 1'b1;
                mem_wr_last = (beat == LAST_BEAT);
                if (mem_wr_rdy && mem_wr_last)
                    state_nxt = POST;
            end
            POST: begin
                // Two idle cycles let the FIFO's delayed occupancy settle
                if (post_cnt)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign hs           = mem_wr_vld & mem_wr_rdy;
    assign stall        = mem_wr_vld & ~mem_wr_rdy;
    assign advance      = hs & mem_wr_last;
    assign burst_rd_en  = hs;
    assign mem_wr_data  = burst_rd_data;
    assign mem_cmd_addr = cmd_addr;
    assign busy         = (state != IDLE);

    always_ff @(posedge rd_clk or posedge wr_rst) begin
        if (wr_rst) begin
            state     <= IDLE;
            beat      <= '0;
            post_cnt  <= 1'b0;
            stall_cnt <= '0;
            cmd_addr  <= AW'(BASE_ADDR);
            err_stall <= 1'b0;
        end else begin
            state    <= state_nxt;
            post_cnt <= (state == POST) && !post_cnt;
            if (start)
                cmd_addr <= wr_ptr;
            if (hs)
                beat <= mem_wr_last ? '0 : beat + 1'b1;
            if (!stall)
                stall_cnt <= '0;
            else if (stall_cnt != STALL_TOP)
                stall_cnt <= stall_cnt + 1'b1;
            if (stall && stall_cnt == STALL_PRE)
                err_stall <= 1'b1;
        end
    end

    audio_ring_addr_gen #(
        .BASE_ADDR (BASE_ADDR),
        .BUF_WORDS (BUF_WORDS),
        .BL        (BL),
        .AW        (AW)
    ) u_addr (
        .clk      (rd_clk),
        .rst      (wr_rst),
        .advance  (advance),
        .ptr      (wr_ptr),
        .wrap_cnt (wrap_cnt)
    );

endmodule

// File: tb/tb_audio_mem_burst_writer.sv
// Directed bench for audio_mem_burst_writer: 32-word ring at base 0x40.
// A simple FWFT FIFO model feeds the DUT and a monitor records memory traffic.
module tb_audio_mem_burst_writer;

    localparam int BL = 16;
    localparam int DW = 36;
    localparam int AW = 24;

    logic          rd_clk = 1'b0;
    logic          wr_rst;
    logic          enable;
    logic          burst_avail;
    logic          burst_rd_en;
    logic [DW-1:0] burst_rd_data;
    logic          mem_cmd_vld;
    logic          mem_cmd_rdy;
    logic [AW-1:0] mem_cmd_addr;
    logic          mem_wr_vld;
    logic          mem_wr_rdy;
    logic [DW-1:0] mem_wr_data;
    logic          mem_wr_last;
    logic [AW-1:0] wr_ptr;
    logic [15:0]   wrap_cnt;
    logic          busy;
    logic          err_stall;

    int ncmp  = 0;
    int nfail = 0;

    logic [DW-1:0] fmem [0:1023];
    int wp = 0;
    int rp = 0;

    logic [AW-1:0] cmds [$];
    logic [DW-1:0] dat  [$];
    logic          lst  [$];

    always #5 rd_clk = ~rd_clk;

    audio_mem_burst_writer #(
        .BL        (BL),
        .DW        (DW),
        .AW        (AW),
        .BASE_ADDR ('h40),
        .BUF_WORDS (32),
        .STALL_MAX (1024)
    ) dut (
        .rd_clk        (rd_clk),
        .wr_rst        (wr_rst),
        .enable        (enable),
        .burst_avail   (burst_avail),
        .burst_rd_en   (burst_rd_en),
        .burst_rd_data (burst_rd_data),
        .mem_cmd_vld   (mem_cmd_vld),
        .mem_cmd_rdy   (mem_cmd_rdy),
        .mem_cmd_addr  (mem_cmd_addr),
        .mem_wr_vld    (mem_wr_vld),
        .mem_wr_rdy    (mem_wr_rdy),
        .mem_wr_data   (mem_wr_data),
        .mem_wr_last   (mem_wr_last),
        .wr_ptr        (wr_ptr),
        .wrap_cnt      (wrap_cnt),
        .busy          (busy),
        .err_stall     (err_stall)
    );

    assign burst_avail   = (wp - rp) >= BL;
    assign burst_rd_data = (wp > rp) ? fmem[rp] : '0;

    always @(posedge rd_clk)
        if (burst_rd_en)
            rp <= rp + 1;

    always @(posedge rd_clk) begin
        if (!wr_rst) begin
            if (mem_cmd_vld && mem_cmd_rdy)
                cmds.push_back(mem_cmd_addr);
            if (mem_wr_vld && mem_wr_rdy) begin
                dat.push_back(mem_wr_data);
                lst.push_back(mem_wr_last);
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int first, input int n);
        for (int i = 0; i < n; i++) begin
            fmem[wp] = DW'(first + i);
            wp++;
        end
    endtask

    task automatic wait_beats(input string tag, input int n, input int budget);
        int k = 0;
        while (dat.size() < n && k < budget) begin
            @(negedge rd_clk);
            k++;
        end
        chk(tag, 64'(dat.size() >= n), 64'd1);
    endtask

    // Counts wrong words and wrong last flags over n beats starting at idx
    function automatic int bad_words(input int idx, input int first, input int n);
        int bad = 0;
        if (dat.size() < idx + n)
            return n;
        for (int i = 0; i < n; i++) begin
            if (dat[idx+i] !== DW'(first + i))
                bad++;
            if (lst[idx+i] !== ((i % BL) == BL - 1))
                bad++;
        end
        return bad;
    endfunction

    initial begin
        int k;
        int r0;
        int n0;
        int c0;

        wr_rst      = 1'b1;
        enable      = 1'b0;
        mem_cmd_rdy = 1'b1;
        mem_wr_rdy  = 1'b1;
        repeat (3) @(negedge rd_clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_cmd_vld", 64'(mem_cmd_vld), 64'd0);
        chk("rst_wr_vld", 64'(mem_wr_vld), 64'd0);
        chk("rst_wr_ptr", 64'(wr_ptr), 64'h40);
        chk("rst_wrap", 64'(wrap_cnt), 64'd0);
        chk("rst_err", 64'(err_stall), 64'd0);

        // Burst 1: single burst, full-rate handshakes
        enable = 1'b1;
        wr_rst = 1'b0;
        @(negedge rd_clk);
        push(0, 16);
        @(negedge rd_clk);
        chk("b1_cmd_vld", 64'(mem_cmd_vld), 64'd1);
        chk("b1_cmd_addr", 64'(mem_cmd_addr), 64'h40);
        @(negedge rd_clk);
        chk("b1_wr_vld", 64'(mem_wr_vld), 64'd1);
        chk("b1_first_data", 64'(mem_wr_data), 64'h0);
        chk("b1_rd_en", 64'(burst_rd_en), 64'd1);
        wait_beats("b1_done", 16, 40);
        chk("b1_post_ptr", 64'(wr_ptr), 64'h50);
        chk("b1_post_busy", 64'(busy), 64'd1);
        @(negedge rd_clk);
        chk("b1_post2_busy", 64'(busy), 64'd1);
        @(negedge rd_clk);
        chk("b1_idle_busy", 64'(busy), 64'd0);
        chk("b1_ncmd", 64'(cmds.size()), 64'd1);
        chk("b1_data", 64'(bad_words(0, 0, 16)), 64'd0);

        // Bursts 2-3: wrap of the 32-word ring
        push(16, 32);
        wait_beats("b2_done", 32, 60);
        chk("b2_wrap", 64'(wrap_cnt), 64'd1);
        chk("b2_ptr", 64'(wr_ptr), 64'h40);
        wait_beats("b3_done", 48, 60);
        repeat (3) @(negedge rd_clk);
        chk("b2_addr", 64'(cmds[1]), 64'h50);
        chk("b3_addr", 64'(cmds[2]), 64'h40);
        chk("b3_ptr", 64'(wr_ptr), 64'h50);
        chk("b3_wrap", 64'(wrap_cnt), 64'd1);
        chk("b23_data", 64'(bad_words(16, 16, 32)), 64'd0);

        // Burst 4: write-data ready toggling every cycle
        r0 = rp;
        push(48, 16);
        k = 0;
        while (dat.size() < 64 && k < 200) begin
            @(negedge rd_clk);
            mem_wr_rdy = ~mem_wr_rdy;
            k++;
        end
        mem_wr_rdy = 1'b1;
        repeat (3) @(negedge rd_clk);
        chk("b4_pops", 64'(rp - r0), 64'd16);
        chk("b4_beats", 64'(dat.size()), 64'd64);
        chk("b4_data", 64'(bad_words(48, 48, 16)), 64'd0);
        chk("b4_addr", 64'(cmds[3]), 64'h50);
        chk("b4_wrap", 64'(wrap_cnt), 64'd2);

        // Burst 5: enable dropped mid-burst with 48 words queued
        push(64, 48);
        wait_beats("b5_beat5", 69, 40);
        enable = 1'b0;
        repeat (30) @(negedge rd_clk);
        chk("b5_beats", 64'(dat.size()), 64'd80);
        chk("b5_ncmd", 64'(cmds.size()), 64'd5);
        chk("b5_fifo_left", 64'(wp - rp), 64'd32);
        chk("b5_busy", 64'(busy), 64'd0);
        enable = 1'b1;
        wait_beats("b7_done", 112, 80);
        repeat (3) @(negedge rd_clk);
        chk("b567_data", 64'(bad_words(64, 64, 48)), 64'd0);
        chk("b7_ptr", 64'(wr_ptr), 64'h50);
        chk("b7_wrap", 64'(wrap_cnt), 64'd3);
        chk("b7_ncmd", 64'(cmds.size()), 64'd7);

        // Burst 8: long write-data stall
        mem_wr_rdy = 1'b0;
        push(112, 16);
        k = 0;
        while (!mem_wr_vld && k < 20) begin
            @(negedge rd_clk);
            k++;
        end
        chk("b8_in_data", 64'(mem_wr_vld), 64'd1);
        repeat (1023) @(negedge rd_clk);
        chk("b8_err_pre", 64'(err_stall), 64'd0);
        @(negedge rd_clk);
        chk("b8_err_set", 64'(err_stall), 64'd1);
        mem_wr_rdy = 1'b1;
        wait_beats("b8_done", 128, 40);
        repeat (3) @(negedge rd_clk);
        chk("b8_err_hold", 64'(err_stall), 64'd1);
        chk("b8_data", 64'(bad_words(112, 112, 16)), 64'd0);
        chk("b8_ptr", 64'(wr_ptr), 64'h40);
        chk("b8_wrap", 64'(wrap_cnt), 64'd4);

        // Burst 9: reset on beat 7, then a fresh burst
        push(128, 16);
        wait_beats("b9_beat7", 135, 40);
        chk("b9_pre_vld", 64'(mem_wr_vld), 64'd1);
        wr_rst = 1'b1;
        #1;
        chk("b9_rst_vld", 64'(mem_wr_vld), 64'd0);
        chk("b9_rst_rd_en", 64'(burst_rd_en), 64'd0);
        chk("b9_rst_last", 64'(mem_wr_last), 64'd0);
        chk("b9_rst_cmd", 64'(mem_cmd_vld), 64'd0);
        chk("b9_rst_busy", 64'(busy), 64'd0);
        chk("b9_rst_ptr", 64'(wr_ptr), 64'h40);
        chk("b9_rst_wrap", 64'(wrap_cnt), 64'd0);
        chk("b9_rst_err", 64'(err_stall), 64'd0);
        wp = rp;
        @(negedge rd_clk);
        wr_rst = 1'b0;
        n0 = dat.size();
        c0 = cmds.size();
        push(200, 16);
        wait_beats("b10_done", n0 + 16, 40);
        repeat (3) @(negedge rd_clk);
        chk("b10_ncmd", 64'(cmds.size()), 64'(c0 + 1));
        if (cmds.size() > c0)
            chk("b10_addr", 64'(cmds[c0]), 64'h40);
        chk("b10_data", 64'(bad_words(n0, 200, 16)), 64'd0);
        chk("b10_ptr", 64'(wr_ptr), 64'h50);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/audio_mem_burst_writer.md
# audio_mem_burst_writer

Drains fixed-length bursts of packed PCM words from the audio write burst FIFO and writes them into a circular audio buffer in external memory through the memory controller's command/write-data ports. Sits directly downstream of the audio burst FIFO, in the memory clock domain (`rd_clk`). Owns buffer address generation, wrap-around, the committed write pointer and the sticky stall error.

## Interface
Parameters:
- `BL`, default `` `MEM_WR_BL `` (16): words per burst.
- `DW`, default `` `DSIZE `` (36): memory data width.
- `AW`, default 24: word address width.
- `BASE_ADDR`, default 0: first word of the audio ring buffer.
- `BUF_WORDS`, default 65536: ring size in words. Must be a nonzero multiple of `BL`.
- `STALL_MAX`, default 1024: consecutive write-data stall cycles before an error.

Ports:
- `rd_clk`  in  1  memory-domain clock; all logic is on its rising edge.
- `wr_rst`  in  1  reset, asynchronous, active-high.
- `enable`  in  1  level; permits starting new bursts.
- `burst_avail`  in  1  FIFO holds at least `BL` words.
- `burst_rd_en`  out  1  FIFO read strobe (FWFT pop).
- `burst_rd_data`  in  DW  FIFO head word (FWFT, valid while not empty).
- `mem_cmd_vld`  out  1  write command valid.
- `mem_cmd_rdy`  in  1  controller accepts command.
- `mem_cmd_addr`  out  AW  burst start word address.
- `mem_wr_vld`  out  1  write data valid.
- `mem_wr_rdy`  in  1  controller accepts data.
- `mem_wr_data`  out  DW  write data.
- `mem_wr_last`  out  1  final beat of burst.
- `wr_ptr`  out  AW  next address to be written, i.e. the committed fill point.
- `wrap_cnt`  out  16  ring wrap count, modulo 2^16.
- `busy`  out  1  state ≠ IDLE.
- `err_stall`  out  1  sticky stall error.

## Operation
- The FSM has four states: IDLE, CMD, DATA, POST.
- **IDLE**
  - If `enable & burst_avail`, latch `mem_cmd_addr <= wr_ptr` and go to CMD.
  - Otherwise stay in IDLE.
- **CMD**
  - `mem_cmd_vld=1`; `mem_cmd_addr` is held stable.
  - On `mem_cmd_rdy`, go to DATA.
- **DATA**
  - `mem_wr_vld=1` and `mem_wr_data=burst_rd_data` (combinational pass-through of the FWFT head).
  - `burst_rd_en = mem_wr_vld & mem_wr_rdy`.
  - The beat counter (`$clog2(BL)` bits) increments on each handshake.
  - `mem_wr_last = (beat==BL-1)`.
  - On the last handshake:
    - `wr_ptr <= wr_ptr+BL`, or `BASE_ADDR` when `wr_ptr+BL == BASE_ADDR+BUF_WORDS`.
    - On a wrap, `wrap_cnt` increments.
    - Go to POST.
- **POST**
  - Hold for exactly 2 cycles, then go to IDLE.
  - This covers the FIFO's registered occupancy plus its one-cycle delayed `burst_avail`, so a stale `burst_avail` is never sampled.
- **Enable**
  - `enable` is sampled only in IDLE.
  - Deassertion mid-burst does not abort; the current burst completes.
- **Stall error**
  - The stall counter counts cycles with `mem_wr_vld & !mem_wr_rdy` and clears on any handshake.
  - Reaching `STALL_MAX` sets `err_stall`. It is cleared only by `wr_rst`; the burst continues.
- **Address arithmetic**
  - Addresses are in word units, unsigned, `AW` bits, with no carry beyond `AW`.
  - `BASE_ADDR+BUF_WORDS ≤ 2^AW`.
- **Reset** (asynchronous, any state, including mid-burst)
  - State returns to IDLE; beat and stall counters clear; `wr_ptr = BASE_ADDR`; `wrap_cnt = 0`; `err_stall = 0`.
  - All strobes (`burst_rd_en`, `mem_cmd_vld`, `mem_wr_vld`, `mem_wr_last`) go to 0; `busy = 0`.
  - A partially written burst is abandoned. The memory controller and the FIFO are reset by the same `wr_rst`.

## Timing
- From `burst_avail` high in IDLE, `mem_cmd_vld` asserts on the next cycle.
- DATA is entered the cycle after the `mem_cmd_vld & mem_cmd_rdy` handshake.
- With `mem_wr_rdy` tied high, one beat is transferred per cycle, so a burst occupies `BL` cycles in DATA.
- Minimum burst period is `1 + 1 + BL + 2` cycles (IDLE, CMD, DATA, POST).
- `mem_wr_data` has zero latency from `burst_rd_data`; `burst_rd_en` is combinational from `mem_wr_rdy`.
- `wr_ptr` and `wrap_cnt` update on the edge that completes the last beat and are visible in the first POST cycle.
- `err_stall` asserts on the edge on which the stall count reaches `STALL_MAX`.

## Structure
- The following live in `defines.v`, alongside `` `PCM_DSIZE ``: `` `MEM_WR_BL ``, `` `DSIZE ``, `` `AUD_BUF_BASE ``, `` `AUD_BUF_WORDS ``, `` `AUD_AW ``.
- State encoding is localparam, local to this module.
- One sub-module, `audio_ring_addr_gen`, holds `wr_ptr`, `wrap_cnt` and the wrap compare.
  - Input: `advance` pulse.
  - Parameters: `BASE_ADDR`, `BUF_WORDS`, `BL`, `AW`.
  - It is reused by the audio readback path.

## Test plan
- Reset, then preload 16 words 0x0…0xF with `mem_*_rdy=1` → one command at address 0x000000, 16 beats of data 0x0…0xF, `mem_wr_last` on beat 15, `wr_ptr=0x000010`.
- `BUF_WORDS=32`, three bursts → command addresses 0, 16, 0; `wrap_cnt=1` after the second burst; `wr_ptr=16` at the end.
- `mem_wr_rdy` toggled 1010… during a burst → exactly 16 pops, data order preserved, no duplicated or dropped word.
- `enable` dropped on beat 5 with 48 words queued → burst completes, no further command, 32 words remain in the FIFO.
- `mem_wr_rdy=0` held for 1024 cycles in DATA → `err_stall=1`, held until reset; after `rdy` returns the burst finishes normally.
- `wr_rst` pulsed on beat 7 → all strobes 0 immediately, `wr_ptr=BASE_ADDR`, `busy=0`; after release the next burst commands `BASE_ADDR`.
